// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer initiator: one bus cycle per valid/ready command,
// response returned on a valid/ready stream, with an ack watchdog and a saturating timeout counter.
module wb_master_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [31:0]      cmd_dat,
  input  logic [3:0]       cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_dat,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic [CNT_W-1:0] timeout_count,
  output logic             busy
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              accept_s;
  logic              illegal_s;
  logic              ack_s;
  logic              expire_s;

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and per-state events; ack only matters while in BUS
  always_comb begin
    next_state_s = state_r;
    cmd_ready    = 1'b0;
    accept_s     = 1'b0;
    illegal_s    = 1'b0;
    ack_s        = 1'b0;
    expire_s     = 1'b0;
    busy         = (state_r != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        cmd_ready = ~wb_rst_i;
        if (cmd_valid) begin
          accept_s = 1'b1;
          if (cmd_we && (cmd_sel == 4'h0)) begin
            illegal_s    = 1'b1;
            next_state_s = ST_RESP;
          end else begin
            next_state_s = ST_BUS;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (wbm_ack_i) begin
          ack_s        = 1'b1;
          next_state_s = ST_RESP;
        end else if (wait_cnt_r == WAIT_LAST) begin
          expire_s     = 1'b1;
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_BUS;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Registered bus and response outputs; ack takes priority over the watchdog
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbm_cyc_o     <= 1'b0;
      wbm_stb_o     <= 1'b0;
      wbm_we_o      <= 1'b0;
      wbm_sel_o     <= 4'h0;
      wbm_adr_o     <= 32'h0000_0000;
      wbm_dat_o     <= 32'h0000_0000;
      rsp_valid     <= 1'b0;
      rsp_dat       <= 32'h0000_0000;
      rsp_err       <= 1'b0;
      timeout_count <= '0;
      wait_cnt_r    <= '0;
    end else begin
      if (accept_s) begin
        wbm_we_o   <= cmd_we;
        wbm_sel_o  <= cmd_sel;
        wbm_adr_o  <= cmd_adr;
        wbm_dat_o  <= cmd_dat;
        wait_cnt_r <= '0;
        if (illegal_s) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_dat   <= 32'h0000_0000;
        end else begin
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
        end
      end
      if (ack_s) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_dat   <= wbm_we_o ? 32'h0000_0000 : wbm_dat_i;
      end else if (expire_s) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_dat   <= 32'h0000_0000;
        if (timeout_count != CNT_MAX) begin
          timeout_count <= timeout_count + CNT_W'(1);
        end
      end else if (state_r == ST_BUS) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end
      if ((state_r == ST_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge against a registered-ack harness model
// that also produces a one-cycle stale ack after strobe drops.
module tb_wb_master_bridge;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'h0;
  logic [31:0] cmd_dat = 32'h0;
  logic [3:0]  cmd_sel = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i;
  logic [7:0]  timeout_count;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  wb_master_bridge #(.TIMEOUT(8), .CNT_W(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .timeout_count(timeout_count), .busy(busy)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Harness model: registered ack (stale for one cycle after stb drops), one
  // memory word at 0x30000000, no response at 0x30000FF0. Poisoned data outside stb.
  logic        ack_q = 1'b0;
  logic [31:0] mem   = 32'h0;
  always @(posedge wb_clk_i) begin
    ack_q <= wbm_cyc_o && wbm_stb_o && (wbm_adr_o != 32'h3000_0FF0);
    if (wbm_cyc_o && wbm_stb_o && wbm_we_o && (wbm_adr_o == 32'h3000_0000)) mem <= wbm_dat_o;
  end
  assign wbm_ack_i = ack_q;
  assign wbm_dat_i = wbm_stb_o ? mem : 32'hDEAD_BEEF;

  // Offers one command, returns observations from the accept edge up to the first rsp_valid cycle.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output int ncyc, output int lat,
                       output logic [31:0] rdat, output logic rerr,
                       output logic [31:0] adr_seen, output logic [3:0] sel_seen,
                       output logic we_seen, output bit stb_ok);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(posedge wb_clk_i); #1;
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = 32'h0BAD_0BAD; cmd_dat = 32'h1234_5678; cmd_sel = 4'h0;
    ncyc = 0; lat = -1; rdat = 32'hx; rerr = 1'bx; stb_ok = 1'b1;
    adr_seen = wbm_adr_o; sel_seen = wbm_sel_o; we_seen = wbm_we_o;
    for (int i = 1; i <= 60 && lat < 0; i++) begin
      if (wbm_cyc_o) ncyc++;
      if (wbm_stb_o !== wbm_cyc_o) stb_ok = 1'b0;
      if (rsp_valid === 1'b1) begin
        lat = i; rdat = rsp_dat; rerr = rsp_err;
      end else begin
        @(posedge wb_clk_i); #1;
      end
    end
  endtask

  int ncyc, lat;
  logic [31:0] rdat, adr_seen;
  logic [3:0] sel_seen;
  logic rerr, we_seen;
  bit stb_ok;

  task automatic test_reset;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0000; cmd_dat = 32'hFFFF_FFFF; cmd_sel = 4'hF;
    repeat (3) @(posedge wb_clk_i);
    #1;
    n_cmp++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin n_bad++; $display("FAIL reset_cyc_stb: got %b%b want 00", wbm_cyc_o, wbm_stb_o); end
    n_cmp++; if (wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || wbm_sel_o !== 4'h0 || wbm_we_o !== 1'b0) begin n_bad++; $display("FAIL reset_bus_regs: got adr=%h dat=%h sel=%h we=%b want zeros", wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o); end
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_dat !== 32'h0 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp: got v=%b d=%h e=%b want 0/0/0", rsp_valid, rsp_dat, rsp_err); end
    n_cmp++; if (timeout_count !== 8'd0) begin n_bad++; $display("FAIL reset_tcount: got %0d want 0", timeout_count); end
    n_cmp++; if (cmd_ready !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_ready_busy: got ready=%b busy=%b want 0 0", cmd_ready, busy); end
    cmd_valid = 1'b0; wb_rst_i = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", cmd_ready); end
    @(posedge wb_clk_i); #1;
    n_cmp++; if (wbm_cyc_o !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_no_accept: got cyc=%b busy=%b want 0 0", wbm_cyc_o, busy); end
  endtask

  task automatic test_write;
    rsp_ready = 1'b1;
    issue(1'b1, 32'h3000_0000, 32'h0000_0003, 4'hF, ncyc, lat, rdat, rerr, adr_seen, sel_seen, we_seen, stb_ok);
    n_cmp++; if (ncyc !== 2) begin n_bad++; $display("FAIL write_cyc_len: got %0d want 2", ncyc); end
    n_cmp++; if (stb_ok !== 1'b1) begin n_bad++; $display("FAIL write_stb_eq_cyc: got %b want 1", stb_ok); end
    n_cmp++; if (adr_seen !== 32'h3000_0000 || sel_seen !== 4'hF || we_seen !== 1'b1) begin n_bad++; $display("FAIL write_bus_fields: got adr=%h sel=%h we=%b want 30000000 f 1", adr_seen, sel_seen, we_seen); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL write_latency: got %0d want 3", lat); end
    n_cmp++; if (rdat !== 32'h0 || rerr !== 1'b0) begin n_bad++; $display("FAIL write_rsp: got d=%h e=%b want 0 0", rdat, rerr); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL write_busy_resp: got %b want 1", busy); end
    @(posedge wb_clk_i); #1;
    n_cmp++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL write_b2b_ready_n4: got ready=%b v=%b want 1 0", cmd_ready, rsp_valid); end
    n_cmp++; if (wbm_adr_o !== 32'h3000_0000 || wbm_dat_o !== 32'h3 || wbm_we_o !== 1'b1) begin n_bad++; $display("FAIL write_hold_after: got adr=%h dat=%h we=%b want held", wbm_adr_o, wbm_dat_o, wbm_we_o); end
  endtask

  task automatic test_read;
    issue(1'b0, 32'h3000_0000, 32'h0, 4'hF, ncyc, lat, rdat, rerr, adr_seen, sel_seen, we_seen, stb_ok);
    n_cmp++; if (lat !== 3 || ncyc !== 2) begin n_bad++; $display("FAIL read_timing: got lat=%0d cyc=%0d want 3 2", lat, ncyc); end
    n_cmp++; if (rdat !== 32'h0000_0003 || rerr !== 1'b0) begin n_bad++; $display("FAIL read_data: got d=%h e=%b want 00000003 0", rdat, rerr); end
    @(posedge wb_clk_i); #1;
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h3000_0000, 32'h0, 4'hF, ncyc, lat, rdat, rerr, adr_seen, sel_seen, we_seen, stb_ok);
    n_cmp++; if (lat !== 3 || rdat !== 32'h3) begin n_bad++; $display("FAIL bp_first: got lat=%0d d=%h want 3 00000003", lat, rdat); end
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0000; cmd_dat = 32'hAAAA_5555; cmd_sel = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(posedge wb_clk_i); #1;
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'h3 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%h e=%b want 1 00000003 0", i, rsp_valid, rsp_dat, rsp_err); end
      n_cmp++; if (cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) begin n_bad++; $display("FAIL bp_no_cmd[%0d]: got ready=%b cyc=%b want 0 0", i, cmd_ready, wbm_cyc_o); end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge wb_clk_i); #1;
    n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got v=%b ready=%b want 0 1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_timeout;
    issue(1'b0, 32'h3000_0FF0, 32'h0, 4'hF, ncyc, lat, rdat, rerr, adr_seen, sel_seen, we_seen, stb_ok);
    n_cmp++; if (ncyc !== 8) begin n_bad++; $display("FAIL tmo_cyc_len: got %0d want 8", ncyc); end
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL tmo_latency: got %0d want 9", lat); end
    n_cmp++; if (rerr !== 1'b1 || rdat !== 32'h0) begin n_bad++; $display("FAIL tmo_rsp: got e=%b d=%h want 1 0", rerr, rdat); end
    n_cmp++; if (timeout_count !== 8'd1) begin n_bad++; $display("FAIL tmo_count1: got %0d want 1", timeout_count); end
    @(posedge wb_clk_i); #1;
  endtask

  task automatic test_illegal;
    issue(1'b1, 32'h3000_0000, 32'h0000_0055, 4'h0, ncyc, lat, rdat, rerr, adr_seen, sel_seen, we_seen, stb_ok);
    n_cmp++; if (ncyc !== 0 || lat !== 1) begin n_bad++; $display("FAIL illegal_timing: got cyc=%0d lat=%0d want 0 1", ncyc, lat); end
    n_cmp++; if (rerr !== 1'b1 || rdat !== 32'h0) begin n_bad++; $display("FAIL illegal_rsp: got e=%b d=%h want 1 0", rerr, rdat); end
    n_cmp++; if (timeout_count !== 8'd1) begin n_bad++; $display("FAIL illegal_tcount: got %0d want 1", timeout_count); end
    @(posedge wb_clk_i); #1;
  endtask

  task automatic test_timeout_saturate;
    for (int k = 2; k <= 300; k++) begin
      issue(1'b0, 32'h3000_0FF0, 32'h0, 4'hF, ncyc, lat, rdat, rerr, adr_seen, sel_seen, we_seen, stb_ok);
      if (k == 254 || k == 255 || k == 256) begin
        n_cmp++; if (timeout_count !== ((k > 255) ? 8'd255 : 8'(k))) begin n_bad++; $display("FAIL tmo_sat_step%0d: got %0d want %0d", k, timeout_count, (k > 255) ? 255 : k); end
      end
      @(posedge wb_clk_i); #1;
    end
    n_cmp++; if (timeout_count !== 8'd255 || rerr !== 1'b1 || ncyc !== 8) begin n_bad++; $display("FAIL tmo_sat_final: got cnt=%0d e=%b cyc=%0d want 255 1 8", timeout_count, rerr, ncyc); end
  endtask

  task automatic test_reset_mid_bus;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0000; cmd_dat = 32'h0; cmd_sel = 4'hF;
    @(posedge wb_clk_i); #1;
    cmd_valid = 1'b0;
    @(posedge wb_clk_i); #1;
    n_cmp++; if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1) begin n_bad++; $display("FAIL rmb_in_bus: got cyc=%b stb=%b want 1 1", wbm_cyc_o, wbm_stb_o); end
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    n_cmp++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rmb_drop: got cyc=%b stb=%b v=%b want 0 0 0", wbm_cyc_o, wbm_stb_o, rsp_valid); end
    n_cmp++; if (timeout_count !== 8'd0 || wbm_adr_o !== 32'h0 || busy !== 1'b0) begin n_bad++; $display("FAIL rmb_clear: got cnt=%0d adr=%h busy=%b want 0 0 0", timeout_count, wbm_adr_o, busy); end
    wb_rst_i = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rmb_ready: got %b want 1", cmd_ready); end
    @(posedge wb_clk_i); #1;
    n_cmp++; if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rmb_no_rsp: got v=%b cyc=%b want 0 0", rsp_valid, wbm_cyc_o); end
    issue(1'b0, 32'h3000_0000, 32'h0, 4'hF, ncyc, lat, rdat, rerr, adr_seen, sel_seen, we_seen, stb_ok);
    n_cmp++; if (lat !== 3 || rdat !== 32'h3 || rerr !== 1'b0) begin n_bad++; $display("FAIL rmb_read_after: got lat=%0d d=%h e=%b want 3 00000003 0", lat, rdat, rerr); end
    @(posedge wb_clk_i); #1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_timeout();
    test_illegal();
    test_timeout_saturate();
    test_reset_mid_bus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Wishbone classic single-transfer initiator. It converts a simple valid/ready command stream into one Wishbone cycle per command and returns a response through a valid/ready response stream.
- Used to drive the multi-project harness slave port from an on-chip sequencer or from a test controller.
- Includes a watchdog that ends unacknowledged cycles with an error, plus a saturating count of those timeouts.

Parameters:
- TIMEOUT, 255, number of BUS cycles without an ack before the cycle is aborted with an error; must be ≥2.
- CNT_W, 8, width of the saturating timeout event counter.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  bridge can accept a command
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  32  byte address
- cmd_dat  in  32  write data
- cmd_sel  in  4  byte selects
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_dat  out  32  read data; 0 for writes and errors
- rsp_err  out  1  1 = timeout or illegal command
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  4  Wishbone byte selects
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone ack
- timeout_count  out  CNT_W  saturating count of timeouts
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered except cmd_ready and busy, which decode the state combinationally.
- FSM states and transitions:
  - IDLE:
    - cmd_ready=1.
    - cmd_valid sampled high at edge N → latch we/adr/dat/sel.
    - Normal command → BUS; cyc/stb=1 from cycle N+1.
    - Illegal command (cmd_we=1 && cmd_sel==0) → RESP directly with rsp_err=1, no bus cycle.
  - BUS:
    - cyc=stb=1; we/sel/adr/dat held stable for the whole cycle.
    - Wait counter clears on entry and increments every BUS cycle.
    - Ack sampled high → capture wbm_dat_i into rsp_dat (reads) or 0 (writes); rsp_err=0; cyc/stb=0 at the same edge; → RESP.
    - Ack still low when the wait counter reaches TIMEOUT-1 → cyc/stb=0, rsp_dat=0, rsp_err=1, timeout_count+1 (saturates at all-ones); → RESP.
    - If ack and the timeout condition occur in the same cycle, ack wins.
  - RESP:
    - rsp_valid=1; rsp_dat and rsp_err held stable.
    - rsp_valid && rsp_ready at an edge → rsp_valid=0; → IDLE.
    - RESP always lasts ≥1 cycle. This guarantees ≥1 idle bus cycle between transfers.
- Ack is ignored outside BUS, so the harness's one-cycle stale ack after stb drops has no effect.
- Latency against the harness (registered ack):
  - Command accepted at edge N; ack visible in cycle N+2; rsp_valid high in cycle N+3.
  - Back-to-back commands with rsp_ready tied high → next cmd_ready in cycle N+4.
- Wishbone outputs are 0 whenever cyc=0, except wbm_adr_o/wbm_dat_o/wbm_sel_o/wbm_we_o, which hold the last values.
- Reset, including mid-cycle:
  - Next edge → IDLE.
  - cyc/stb/we=0, sel=0, adr=0, dat=0.
  - rsp_valid=0, rsp_dat=0, rsp_err=0, timeout_count=0.
  - Any in-flight transaction is dropped with no response.
- cmd_valid asserted during reset is not accepted.
- Command accepted only when cmd_valid && cmd_ready; no queuing; cmd_* values are don't-care outside the accept edge.

Test Plan:
- Write: cmd_we=1, adr=0x30000000, dat=0x00000003, sel=0xF, against the harness → one cycle with cyc/stb high for exactly 2 clocks; rsp_valid in cycle N+3 with rsp_err=0, rsp_dat=0.
- Read back: cmd_we=0, adr=0x30000000, sel=0xF → rsp_dat=0x00000003, rsp_err=0, latency 3.
- Timeout: adr=0x30000FF0, no ack, TIMEOUT=8 → cyc high exactly 8 cycles; rsp_err=1, rsp_dat=0, timeout_count=1. Repeat 300× with CNT_W=8 → timeout_count saturates at 255.
- Back-pressure and stale ack: hold rsp_ready=0 for 10 cycles → rsp_valid and rsp_dat stable, cmd_ready=0, no new cyc. The stale ack in the first RESP cycle does not re-capture data.
- Illegal command: cmd_we=1, sel=0 → no cyc; rsp_valid next cycle with rsp_err=1; timeout_count unchanged.
- Reset mid-BUS: assert wb_rst_i in the 2nd BUS cycle → next edge cyc=stb=0, rsp_valid=0, cmd_ready=1 after release; a subsequent read completes normally.
